uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Byte-wide transmit FIFO placed directly upstream of the UART core's transmit side. It accepts bytes from a host over a valid/ready handshake and buffers up to 2^DEPTH_LOG2 of them. It feeds the UART core one byte at a time using the core's single-cycle transmit strobe and its is_transmitting status. It turns bursty host writes into back-to-back serial frames with no host-side polling.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries); legal range 1..8.
START_TIMEOUT, 3, cycles to wait for uart_is_transmitting to rise after a strobe before re-issuing the strobe.

Ports:
clk  input  1  master clock, shared with the UART core
rst  input  1  synchronous, active-high reset
in_data  input  8  byte from host
in_valid  input  1  host has a byte on in_data
in_ready  output  1  FIFO can accept; a push occurs on a cycle where in_valid & in_ready
uart_transmit  output  1  one-cycle start strobe to the UART core
uart_tx_byte  output  8  byte presented to the UART core; registered
uart_is_transmitting  input  1  UART core busy flag
count  output  DEPTH_LOG2+1  current FIFO occupancy
empty  output  1  count == 0
full  output  1  count == 2^DEPTH_LOG2
busy  output  1  ~empty, or FSM not in IDLE

Behaviour:
- Reset (rst high at a clk edge):
  - Pointers and count go to 0; FSM goes to IDLE; uart_transmit=0; uart_tx_byte=8'h00.
  - in_ready = ~full & ~rst, so it is 0 during any reset cycle and 1 the cycle after.
  - A push presented during a reset cycle is dropped.
- Reset mid-operation:
  - FIFO contents are discarded and the strobe is deasserted.
  - An in-flight UART frame is not aborted by this block.
- Storage: memory array with DEPTH_LOG2-bit read/write pointers that wrap modulo depth; count is tracked separately.
- Push: in_valid & in_ready writes mem[wr_ptr], increments wr_ptr, and increments count.
- No bypass when full: in_ready is low when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop (not full): count unchanged; both pointers advance.
- FSM states: IDLE, ISSUE, WAIT_START, BUSY.
- IDLE:
  - Condition: ~empty & ~uart_is_transmitting at the edge.
  - Action: uart_tx_byte<=mem[rd_ptr], rd_ptr++, count--, uart_transmit<=1; next state ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - uart_transmit<=0; timer<=0; next state WAIT_START.
  - uart_transmit is therefore high for exactly one cycle.
- WAIT_START:
  - If uart_is_transmitting: next state BUSY.
  - Else timer++. When timer reaches START_TIMEOUT: uart_transmit<=1 with the same held byte (no pop); next state ISSUE.
  - Retries are unbounded, and bytes are never lost.
- BUSY:
  - When ~uart_is_transmitting: next state IDLE.
  - The next byte can be issued at the following edge, giving back-to-back frames.
- uart_tx_byte holds its value until the next pop.
- Latency:
  - Push accepted at edge E0 into an empty, idle FIFO gives uart_transmit high in the cycle after edge E1.
  - That is one cycle after the write cycle.
- Ordering: strict FIFO. Each popped byte is strobed exactly once after a successful start; retries re-strobe the same byte.
- count width DEPTH_LOG2+1 so it represents full without wrap.
- Derived flags: empty/full are derived from count; busy=~empty|(state!=IDLE).

Test Plan:
1. Reset, then push 8'hA5 at cycle 0 with a model UART that raises is_transmitting 1 cycle after the strobe -> uart_transmit high only in cycle 1; uart_tx_byte=8'hA5; returns to IDLE after is_transmitting falls; count=0, busy=0.
2. Push 16 bytes 8'h00..8'h0F back-to-back while the UART model is held busy -> count reaches 16; full=1; in_ready=0; a 17th in_valid is not accepted.
   Release the UART -> bytes emerge in order 00..0F, one strobe per frame.
3. At full, release the UART and hold in_valid on the same cycle -> no push that cycle (in_ready=0); count goes 16->15; next cycle push accepted, count back to 16.
4. UART model ignores the first strobe (is_transmitting stays 0) -> after 3 cycles in WAIT_START a second one-cycle strobe with the same byte; count not decremented again; after a later ack, normal flow.
5. Push 3 bytes, assert rst for 1 cycle while the first is in BUSY -> uart_transmit=0; count=0; empty=1; in_ready=0 during reset, 1 after; nothing further is strobed.
6. Wrap test: 40 push/pop cycles with random gaps at DEPTH_LOG2=2 -> output sequence equals input sequence; count never exceeds 4; no spurious strobes.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte-wide transmit FIFO in front of a UART core. Host bytes
//               come in over valid/ready. Buffered bytes go to the core one
//               at a time using a one-cycle start strobe. If the core does
//               not acknowledge a strobe through is_transmitting, the same
//               byte is strobed again.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH_LOG2    = 4,
    parameter int START_TIMEOUT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  uart_transmit,
    output logic [7:0]            uart_tx_byte,
    input  logic                  uart_is_transmitting,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  busy
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    // The timer only has to count 0 .. START_TIMEOUT-1.
    localparam int c_TMR_W = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT);
    localparam logic [c_TMR_W-1:0]  c_TMR_LAST = c_TMR_W'(START_TIMEOUT - 1);
    localparam logic [DEPTH_LOG2:0] c_FULL     = (DEPTH_LOG2 + 1)'(c_DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_BUSY  = 2'd3;

    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [c_TMR_W-1:0]    r_timer;
    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_transmit;
    logic [7:0]            r_tx_byte;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_in_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_retry;
    logic                  w_timer_clr;
    logic                  w_timer_inc;

    // Occupancy flags and host handshake. in_ready drops during reset so a
    // push offered in a reset cycle is never accepted.
    always_comb begin
        w_empty    = (r_count == '0);
        w_full     = (r_count == c_FULL);
        w_in_ready = ~w_full & ~rst;
        w_push     = in_valid & w_in_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for the strobe/acknowledge handshake with the core.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (uart_is_transmitting) begin
                    w_state_nxt = c_ST_BUSY;
                end else if (r_timer == c_TMR_LAST) begin
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_BUSY: begin
                if (!uart_is_transmitting) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // FSM control outputs: pop a new byte, re-strobe a held byte, run timer.
    always_comb begin
        w_pop       = (r_state == c_ST_IDLE) & ~w_empty & ~uart_is_transmitting;
        w_retry     = (r_state == c_ST_WAIT) & ~uart_is_transmitting
                      & (r_timer == c_TMR_LAST);
        w_timer_clr = (r_state == c_ST_ISSUE);
        w_timer_inc = (r_state == c_ST_WAIT) & ~uart_is_transmitting
                      & (r_timer != c_TMR_LAST);
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy, strobe, held byte and start timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_timer    <= '0;
            r_transmit <= 1'b0;
            r_tx_byte  <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + DEPTH_LOG2'(1);
                r_tx_byte <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
                default: r_count <= r_count;
            endcase
            // A retry re-strobes the byte already held in r_tx_byte.
            r_transmit <= w_pop | w_retry;
            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (w_timer_inc) begin
                r_timer <= r_timer + c_TMR_W'(1);
            end
        end
    end

    // Output assignments.
    always_comb begin
        in_ready      = w_in_ready;
        uart_transmit = r_transmit;
        uart_tx_byte  = r_tx_byte;
        count         = r_count;
        empty         = w_empty;
        full          = w_full;
        busy          = ~w_empty | (r_state != c_ST_IDLE);
    end

endmodule
`default_nettype wire
